// File: rtl/bool_pkg.sv
// Shared definitions for the boolean gate unit self-test engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bool_pkg;

    localparam int NUM_VEC = 4;
    localparam int RSP_W   = 5;

    // Bit positions inside a response vector {nand,or,and,not_b,not_a}
    localparam int RSP_NOT_A = 0;
    localparam int RSP_NOT_B = 1;
    localparam int RSP_AND   = 2;
    localparam int RSP_OR    = 3;
    localparam int RSP_NAND  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Expected gate unit response for one (a,b) stimulus pair
    function automatic logic [RSP_W-1:0] golden_rsp(input logic a, input logic b);
        logic [RSP_W-1:0] r;
        r            = '0;
        r[RSP_NOT_A] = ~a;
        r[RSP_NOT_B] = ~b;
        r[RSP_AND]   = a & b;
        r[RSP_OR]    = a | b;
        r[RSP_NAND]  = ~(a & b);
        return r;
    endfunction

endpackage

// File: rtl/bool_golden.sv
// Golden model of the two-input gate unit: (a,b) -> expected 5-bit response.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the inputs.
// Ports: i_a, i_b stimulus; o_rsp expected {nand,or,and,not_b,not_a}.
module bool_golden
    import bool_pkg::*;
(
    input  logic             i_a,
    input  logic             i_b,
    output logic [RSP_W-1:0] o_rsp
);

    assign o_rsp = golden_rsp(i_a, i_b);

endmodule

// File: rtl/bool_self_test.sv
// Sweeps the four (a,b) vectors into an external gate unit and checks its responses.
// Latency: done pulses in the (1 + 4*(SETTLE+1))-th cycle after the start edge.
// Backpressure: none; start is only accepted in IDLE, never queued.
// Ports: clk/reset (async, active-high); start; dut_a/dut_b stimulus out;
//        dut_not_a/not_b/and/or/nand responses in; busy, done, pass, err_count,
//        fail_mask, first_fail_vec, first_fail_bits results.
module bool_self_test
    import bool_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               dut_a,
    output logic               dut_b,
    input  logic               dut_not_a,
    input  logic               dut_not_b,
    input  logic               dut_and,
    input  logic               dut_or,
    input  logic               dut_nand,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [NUM_VEC-1:0] fail_mask,
    output logic [1:0]         first_fail_vec,
    output logic [RSP_W-1:0]   first_fail_bits
);

    // Settle counter only needs to hold SETTLE-1
    localparam int SC_W  = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int SUM_W = CNT_W + 3;

    generate
        if (SETTLE < 1) begin : g_bad_settle
            initial $error("bool_self_test: SETTLE must be >= 1, got %0d", SETTLE);
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_vec;
    logic [SC_W-1:0]    r_cnt;
    logic               r_a;
    logic               r_b;
    logic [RSP_W-1:0]   r_rsp;
    logic               r_pass;
    logic [CNT_W-1:0]   r_err;
    logic [NUM_VEC-1:0] r_mask;
    logic [1:0]         r_ffv;
    logic [RSP_W-1:0]   r_ffb;

    logic               w_launch;
    logic               w_cnt_dec;
    logic               w_commit;
    logic               w_busy;
    logic               w_done;
    logic [RSP_W-1:0]   w_rsp_in;
    logic [RSP_W-1:0]   w_gold;
    logic [RSP_W-1:0]   w_xor;
    logic [2:0]         w_pop;
    logic [SUM_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_err_nxt;
    logic [1:0]         w_vec_inc;

    bool_golden u_golden (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_rsp (w_gold)
    );

    always_comb begin
        w_rsp_in            = '0;
        w_rsp_in[RSP_NOT_A] = dut_not_a;
        w_rsp_in[RSP_NOT_B] = dut_not_b;
        w_rsp_in[RSP_AND]   = dut_and;
        w_rsp_in[RSP_OR]    = dut_or;
        w_rsp_in[RSP_NAND]  = dut_nand;
    end

    assign w_xor     = r_rsp ^ w_gold;
    assign w_pop     = 3'($countones(w_xor));
    assign w_sum     = SUM_W'(r_err) + SUM_W'(w_pop);
    // Any carry above the counter width means the count has saturated
    assign w_err_nxt = (|w_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_vec_inc = r_vec + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_cnt_dec   = 1'b0;
        w_commit    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            CHECK: begin
                w_busy      = 1'b1;
                w_commit    = 1'b1;
                w_state_nxt = (r_vec == 2'd3) ? DONE : WAIT;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec  <= '0;
            r_cnt  <= '0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_rsp  <= '0;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_mask <= '0;
            r_ffv  <= '0;
            r_ffb  <= '0;
        end else begin
            // Responses are registered every cycle; CHECK looks at the sample
            // taken on the edge that left WAIT.
            r_rsp <= w_rsp_in;
            if (w_launch) begin
                r_vec  <= '0;
                r_a    <= 1'b0;
                r_b    <= 1'b0;
                r_cnt  <= SC_W'(SETTLE - 1);
                r_pass <= 1'b0;
                r_err  <= '0;
                r_mask <= '0;
                r_ffv  <= '0;
                r_ffb  <= '0;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (w_commit) begin
                r_err         <= w_err_nxt;
                r_mask[r_vec] <= |w_xor;
                // Mask still empty means no earlier vector of this sweep failed
                if ((|w_xor) && (r_mask == '0)) begin
                    r_ffv <= r_vec;
                    r_ffb <= w_xor;
                end
                if (r_vec == 2'd3) begin
                    r_pass <= (w_err_nxt == '0);
                end else begin
                    r_vec <= w_vec_inc;
                    r_a   <= w_vec_inc[0];
                    r_b   <= w_vec_inc[1];
                    r_cnt <= SC_W'(SETTLE - 1);
                end
            end
        end
    end

    assign dut_a           = r_a;
    assign dut_b           = r_b;
    assign busy            = w_busy;
    assign done            = w_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign fail_mask       = r_mask;
    assign first_fail_vec  = r_ffv;
    assign first_fail_bits = r_ffb;

endmodule

// File: tb/tb_bool_self_test.sv
// Bench for bool_self_test: three engines (SETTLE=2 direct, SETTLE=1 and
// SETTLE=3 behind a 2-cycle delayed gate unit) with a results scoreboard.
module tb_bool_self_test;

    localparam int NI    = 3;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             start     [NI];
    logic             s_a       [NI];
    logic             s_b       [NI];
    logic             busy      [NI];
    logic             done      [NI];
    logic             pass      [NI];
    logic [CNT_W-1:0] err_count [NI];
    logic [3:0]       fail_mask [NI];
    logic [1:0]       ffv       [NI];
    logic [4:0]       ffb       [NI];

    int mode0 = 0;   // 0 good, 1 NAND stuck-at-0, 2 AND/OR swapped

    typedef struct {
        bit         exact;
        logic       pass;
        logic [4:0] err;
        logic [3:0] mask;
        logic [1:0] ffv;
        logic [4:0] ffb;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Gate unit model, response order {nand,or,and,not_b,not_a}
    function automatic logic [4:0] bench_gate(input int m, input logic a, input logic b);
        logic n_a, n_b, g_and, g_or, g_nand;
        n_a    = !a;
        n_b    = !b;
        g_and  = a && b;
        g_or   = a || b;
        g_nand = !(a && b);
        if (m == 1) g_nand = 1'b0;
        if (m == 2) {g_and, g_or} = {g_or, g_and};
        return {g_nand, g_or, g_and, n_b, n_a};
    endfunction

    logic [4:0] rsp0;
    logic [4:0] d1_1 = '0, d2_1 = '0, d1_2 = '0, d2_2 = '0;
    assign rsp0 = bench_gate(mode0, s_a[0], s_b[0]);
    always @(posedge clk) begin
        d1_1 <= bench_gate(0, s_a[1], s_b[1]);
        d2_1 <= d1_1;
        d1_2 <= bench_gate(0, s_a[2], s_b[2]);
        d2_2 <= d1_2;
    end

    bool_self_test #(.SETTLE(2), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .dut_a(s_a[0]), .dut_b(s_b[0]),
        .dut_not_a(rsp0[0]), .dut_not_b(rsp0[1]), .dut_and(rsp0[2]), .dut_or(rsp0[3]),
        .dut_nand(rsp0[4]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_count[0]), .fail_mask(fail_mask[0]),
        .first_fail_vec(ffv[0]), .first_fail_bits(ffb[0]));

    bool_self_test #(.SETTLE(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .dut_a(s_a[1]), .dut_b(s_b[1]),
        .dut_not_a(d2_1[0]), .dut_not_b(d2_1[1]), .dut_and(d2_1[2]), .dut_or(d2_1[3]),
        .dut_nand(d2_1[4]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_count[1]), .fail_mask(fail_mask[1]),
        .first_fail_vec(ffv[1]), .first_fail_bits(ffb[1]));

    bool_self_test #(.SETTLE(3), .CNT_W(CNT_W)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .dut_a(s_a[2]), .dut_b(s_b[2]),
        .dut_not_a(d2_2[0]), .dut_not_b(d2_2[1]), .dut_and(d2_2[2]), .dut_or(d2_2[3]),
        .dut_nand(d2_2[4]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err_count[2]), .fail_mask(fail_mask[2]),
        .first_fail_vec(ffv[2]), .first_fail_bits(ffb[2]));

    logic       g_a, g_b;
    logic [4:0] g_rsp;
    bool_golden u_gold (.i_a(g_a), .i_b(g_b), .o_rsp(g_rsp));

    task automatic push_exp(input bit exact, input logic p, input logic [4:0] e,
                            input logic [3:0] m, input logic [1:0] v, input logic [4:0] b);
        exp_t x;
        x.exact = exact; x.pass = p; x.err = e; x.mask = m; x.ffv = v; x.ffb = b;
        sb.push_back(x);
    endtask

    // One full sweep on engine i; optionally re-pulses start while busy / in DONE.
    task automatic run_sweep(input int i, input int settle, input bit repulse);
        int   hold, total;
        bit   have;
        exp_t e;
        hold  = settle + 1;
        total = 4 * hold + 1;
        have  = 0;
        @(negedge clk); start[i] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= total + 3; c++) begin
            @(negedge clk);
            start[i] = repulse && (c == 4 || c == total - 1 || c == total);
            if (c == 1) begin
                n_chk++;
                if ({pass[i], err_count[i], fail_mask[i], ffv[i], ffb[i]} !== '0) begin
                    n_err++;
                    $display("FAIL clear_at_start inst%0d: pass=%b err=%0d mask=%b ffv=%0d ffb=%b, required all 0",
                             i, pass[i], err_count[i], fail_mask[i], ffv[i], ffb[i]);
                end
            end
            if (c < total) begin
                n_chk++;
                if (busy[i] !== 1'b1 || done[i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_c%0d inst%0d: busy=%b done=%b, required busy=1 done=0", c, i, busy[i], done[i]);
                end
                n_chk++;
                if ({s_b[i], s_a[i]} !== 2'((c - 1) / hold)) begin
                    n_err++;
                    $display("FAIL stim_c%0d inst%0d: {b,a}=%b, required %0d", c, i, {s_b[i], s_a[i]}, (c - 1) / hold);
                end
            end else if (c == total) begin
                n_chk++;
                if (done[i] !== 1'b1 || busy[i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_c%0d inst%0d: done=%b busy=%b, required done=1 busy=0", c, i, done[i], busy[i]);
                end
                if (done[i] === 1'b1 && sb.size() > 0) begin
                    e    = sb.pop_front();
                    have = 1;
                    n_chk++;
                    if (pass[i] !== e.pass) begin
                        n_err++;
                        $display("FAIL pass inst%0d: got %b, required %b", i, pass[i], e.pass);
                    end
                    if (e.exact) begin
                        n_chk++;
                        if (err_count[i] !== e.err) begin
                            n_err++;
                            $display("FAIL err_count inst%0d: got %0d, required %0d", i, err_count[i], e.err);
                        end
                        n_chk++;
                        if (fail_mask[i] !== e.mask) begin
                            n_err++;
                            $display("FAIL fail_mask inst%0d: got %b, required %b", i, fail_mask[i], e.mask);
                        end
                        n_chk++;
                        if (ffv[i] !== e.ffv || ffb[i] !== e.ffb) begin
                            n_err++;
                            $display("FAIL first_fail inst%0d: vec=%0d bits=%b, required vec=%0d bits=%b",
                                     i, ffv[i], ffb[i], e.ffv, e.ffb);
                        end
                    end else begin
                        n_chk++;
                        if (fail_mask[i] === 4'b0) begin
                            n_err++;
                            $display("FAIL fail_mask_nonzero inst%0d: got %b, required nonzero", i, fail_mask[i]);
                        end
                    end
                end
            end else begin
                n_chk++;
                if (done[i] !== 1'b0 || busy[i] !== 1'b0 || {s_b[i], s_a[i]} !== 2'd3) begin
                    n_err++;
                    $display("FAIL after_done_c%0d inst%0d: done=%b busy=%b {b,a}=%b, required 0 0 11",
                             c, i, done[i], busy[i], {s_b[i], s_a[i]});
                end
                if (have && e.exact) begin
                    n_chk++;
                    if (pass[i] !== e.pass || err_count[i] !== e.err) begin
                        n_err++;
                        $display("FAIL result_hold_c%0d inst%0d: pass=%b err=%0d, required %b %0d",
                                 c, i, pass[i], err_count[i], e.pass, e.err);
                    end
                end
            end
        end
        if (!have) begin
            n_chk++; n_err++;
            $display("FAIL no_done inst%0d: no done in cycle %0d, required one", i, total);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_chk++;
            if ({s_a[i], s_b[i], busy[i], done[i], pass[i], err_count[i], fail_mask[i], ffv[i], ffb[i]} !== '0) begin
                n_err++;
                $display("FAIL reset_state inst%0d: a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b ffv=%0d ffb=%b, required all 0",
                         i, s_a[i], s_b[i], busy[i], done[i], pass[i], err_count[i], fail_mask[i], ffv[i], ffb[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_golden;
        for (int v = 0; v < 4; v++) begin
            g_a = v[0]; g_b = v[1];
            #1;
            n_chk++;
            if (g_rsp !== bench_gate(0, g_a, g_b)) begin
                n_err++;
                $display("FAIL golden_v%0d: got %b, required %b", v, g_rsp, bench_gate(0, g_a, g_b));
            end
        end
    endtask

    task automatic test_pass;
        mode0 = 0;
        push_exp(1, 1'b1, 5'd0, 4'b0000, 2'd0, 5'b00000);
        run_sweep(0, 2, 0);
    endtask

    task automatic test_nand_stuck;
        mode0 = 1;
        push_exp(1, 1'b0, 5'd3, 4'b0111, 2'd0, 5'b10000);
        run_sweep(0, 2, 0);
    endtask

    task automatic test_and_or_swap;
        mode0 = 2;
        push_exp(1, 1'b0, 5'd4, 4'b0110, 2'd1, 5'b01100);
        run_sweep(0, 2, 0);
    endtask

    task automatic test_back_to_back;
        mode0 = 1;
        push_exp(1, 1'b0, 5'd3, 4'b0111, 2'd0, 5'b10000);
        run_sweep(0, 2, 1);
        mode0 = 0;
        push_exp(1, 1'b1, 5'd0, 4'b0000, 2'd0, 5'b00000);
        run_sweep(0, 2, 0);
    endtask

    task automatic test_reset_mid_sweep;
        mode0 = 1;
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); start[0] = 1'b0;
        repeat (6) @(negedge clk);   // cycle 7: WAIT of vector 2
        n_chk++;
        if ({s_b[0], s_a[0]} !== 2'd2 || err_count[0] !== 5'd2 || fail_mask[0] !== 4'b0011 || busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: {b,a}=%b err=%0d mask=%b busy=%b, required 10 2 0011 1",
                     {s_b[0], s_a[0]}, err_count[0], fail_mask[0], busy[0]);
        end
        #1 reset = 1'b1;
        #1;
        n_chk++;
        if ({s_a[0], s_b[0], busy[0], done[0], pass[0], err_count[0], fail_mask[0], ffv[0], ffb[0]} !== '0) begin
            n_err++;
            $display("FAIL async_reset: a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b ffv=%0d ffb=%b, required all 0",
                     s_a[0], s_b[0], busy[0], done[0], pass[0], err_count[0], fail_mask[0], ffv[0], ffb[0]);
        end
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: done=%b busy=%b, required 0 0", done[0], busy[0]);
            end
        end
        reset = 1'b0;
        mode0 = 0;
        push_exp(1, 1'b1, 5'd0, 4'b0000, 2'd0, 5'b00000);
        run_sweep(0, 2, 0);
    endtask

    task automatic test_settle;
        push_exp(0, 1'b0, 5'd0, 4'b0000, 2'd0, 5'b00000);
        run_sweep(1, 1, 0);
        push_exp(1, 1'b1, 5'd0, 4'b0000, 2'd0, 5'b00000);
        run_sweep(2, 3, 0);
    endtask

    initial begin
        g_a = 1'b0; g_b = 1'b0;
        test_reset;
        test_golden;
        test_pass;
        test_nand_stuck;
        test_and_or_swap;
        test_back_to_back;
        test_reset_mid_sweep;
        test_settle;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bool_self_test.md
Name: bool_self_test

Overview:
Sequential stimulus-and-check engine for the two-input boolean gate unit: the hardware counterpart of the gate unit's bench, so the same check runs in silicon and in simulation.
- Drives the four (a,b) combinations into an external gate unit.
- Waits a settle interval, then samples its five responses (NOT a, NOT b, AND, OR, NAND) and compares them against a golden model.
- Reports pass/fail, a per-vector fail mask, a bit-error count and the first failure.

Parameters:
SETTLE, 2, cycles dut_a/dut_b are held before responses are sampled; legal range >= 1
CNT_W, 5, width of the saturating bit-error counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a sweep; sampled in IDLE only
dut_a  out  1  stimulus a to the gate unit
dut_b  out  1  stimulus b to the gate unit
dut_not_a  in  1  gate unit response ~a
dut_not_b  in  1  gate unit response ~b
dut_and  in  1  gate unit response a&b
dut_or  in  1  gate unit response a|b
dut_nand  in  1  gate unit response ~(a&b)
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of sweep
pass  out  1  1 if the last sweep had zero mismatches; held until the next start
err_count  out  CNT_W  total mismatched response bits in the last sweep, saturating at 2^CNT_W-1
fail_mask  out  4  bit i set if vector i had any mismatch
first_fail_vec  out  2  index of the first failing vector
first_fail_bits  out  5  XOR mask of the first failing vector, bit order {nand,or,and,not_b,not_a}

Behaviour:
- One clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values: all outputs 0, state IDLE, vector index 0.
- Vector index v = {b,a}, a is the LSB. Applied order is (a,b) = 00, 10, 01, 11, i.e. v = 0,1,2,3.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 -> WAIT.
  - On that edge: v=0, dut_a/dut_b drive vector 0, settle counter = SETTLE-1, busy=1.
  - On that edge, clear pass, err_count, fail_mask, first_fail_vec and first_fail_bits.
- WAIT: counter==0 -> CHECK, else decrement. WAIT lasts exactly SETTLE cycles.
- CHECK:
  - Compare the registered response vector with the golden vector {~(a&b), a|b, a&b, ~b, ~a}.
  - On the exit edge:
    - err_count += popcount(xor), saturating.
    - fail_mask[v] = |xor.
    - If this is the first failing vector of the sweep, latch first_fail_vec = v and first_fail_bits = xor.
  - v==3 -> DONE. Otherwise v++, drive the next vector, reload the counter, -> WAIT.
- DONE: done=1 and busy=0 for this one cycle; pass = (err_count==0) becomes valid this cycle. -> IDLE.
- Timing:
  - Each vector is held SETTLE+1 cycles.
  - done is asserted 1 + 4*(SETTLE+1) cycles after the edge that samples start (13 cycles for SETTLE=2).
- dut_a/dut_b hold vector 3 after the sweep until the next start or reset.
- start is ignored in WAIT, CHECK and DONE; there is no queuing.
- Reset mid-sweep: all outputs clear immediately (asynchronous), no done pulse, results are lost. The next start runs a full sweep.
- Saturation: err_count never wraps. The maximum per sweep is 20, so the default CNT_W never saturates.
- SETTLE=0 is illegal: flag with a simulation-time error in an initial block.

Decomposition:
- Shared package/header (bool_pkg):
  - NUM_VEC=4.
  - Response bit indices RSP_NOT_A=0, RSP_NOT_B=1, RSP_AND=2, RSP_OR=3, RSP_NAND=4.
  - State encodings.
  - The golden-response function.
- Sub-module bool_golden: combinational golden model, (a,b) -> 5-bit expected vector. It is reused by the bench scoreboard.

Test Plan:
1. Correct gate unit wired back, SETTLE=2, start pulse -> done 13 cycles later, pass=1, err_count=0, fail_mask=0000; dut_a/dut_b sequence 00,10,01,11, each held 3 cycles.
2. NAND stuck-at-0 -> pass=0, err_count=3, fail_mask=0111, first_fail_vec=0, first_fail_bits=10000.
3. AND/OR outputs swapped -> err_count=4, fail_mask=0110, first_fail_vec=1, first_fail_bits=01100.
4. start re-pulsed while busy -> ignored, done occurs once at cycle 13. A second start after done clears the results at its edge and a fresh sweep completes.
5. reset asserted during WAIT of vector 2 -> all outputs 0 in the same cycle, no done. A later start gives a full 13-cycle sweep with correct results.
6. Gate unit behind a 2-cycle register delay: SETTLE=1 -> pass=0 with nonzero fail_mask; SETTLE=3 -> pass=1.
